// File: rtl/aes256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_pkg
//  Description : Shared constants, FSM state encoding and GF(2^8) helper
//                functions for the iterative AES-256 encrypt path.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes256_pkg;

    // Number of AES rounds for a 256-bit key.
    localparam int AES256_NR = 14;

    // Width of the round-key index (must hold 0..AES256_NR).
    localparam int RKW = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add over the bits of b.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    // AES S-box: field inverse followed by the fixed affine transform.
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes256_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_round_ctrl_if
//  Description : Host block interface and key-schedule request/valid bus of
//                the AES-256 round sequencer. The slave modport is the
//                sequencer's view; master is the host / key-RAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes256_round_ctrl_if #(
    parameter int RKW = aes256_pkg::RKW
);
    logic           start_i;
    logic [127:0]   data_i;
    logic           ready_o;
    logic           rk_req_o;
    logic [RKW-1:0] rk_idx_o;
    logic           rk_valid_i;
    logic [127:0]   round_key_i;
    logic           valid_o;
    logic [127:0]   data_o;
    logic           ready_i;

    modport slave (
        input  start_i, data_i, rk_valid_i, round_key_i, ready_i,
        output ready_o, rk_req_o, rk_idx_o, valid_o, data_o
    );

    modport master (
        output start_i, data_i, rk_valid_i, round_key_i, ready_i,
        input  ready_o, rk_req_o, rk_idx_o, valid_o, data_o
    );

endinterface
`default_nettype wire

// File: rtl/aes256_addroundkey.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_addroundkey
//  Description : AES AddRoundKey - bitwise XOR of state and round key.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_addroundkey (
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o
);

    assign state_o = state_i ^ key_i;

endmodule
`default_nettype wire

// File: rtl/aes256_round_func.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_round_func
//  Description : Combinational AES round body: SubBytes, ShiftRows and
//                MixColumns. last_i bypasses MixColumns for the final round.
//                Byte k of the state sits in bits [127-8k -: 8]; the state
//                is column-major, byte k = row (k % 4), column (k / 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_round_func
    import aes256_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    // Byte 0 lands on index 0 because the packed range runs 0 to 15.
    logic [0:15][7:0] w_in;
    logic [0:15][7:0] w_sb;
    logic [0:15][7:0] w_sr;
    logic [0:15][7:0] w_mc;

    assign w_in = state_i;

    // SubBytes on every byte independently.
    for (genvar k = 0; k < 16; k++) begin : g_sub
        assign w_sb[k] = aes_sbox(w_in[k]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        // ShiftRows: row r rotates left by r columns.
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[4*c + r] = w_sb[4*((c + r) % 4) + r];
        end

        // MixColumns on column c with the circulant {02,03,01,01}.
        assign w_mc[4*c + 0] = xtime(w_sr[4*c + 0]) ^ xtime(w_sr[4*c + 1]) ^ w_sr[4*c + 1]
                             ^ w_sr[4*c + 2] ^ w_sr[4*c + 3];
        assign w_mc[4*c + 1] = w_sr[4*c + 0] ^ xtime(w_sr[4*c + 1]) ^ xtime(w_sr[4*c + 2])
                             ^ w_sr[4*c + 2] ^ w_sr[4*c + 3];
        assign w_mc[4*c + 2] = w_sr[4*c + 0] ^ w_sr[4*c + 1] ^ xtime(w_sr[4*c + 2])
                             ^ xtime(w_sr[4*c + 3]) ^ w_sr[4*c + 3];
        assign w_mc[4*c + 3] = xtime(w_sr[4*c + 0]) ^ w_sr[4*c + 0] ^ w_sr[4*c + 1]
                             ^ w_sr[4*c + 2] ^ xtime(w_sr[4*c + 3]);
    end

    assign state_o = last_i ? w_sr : w_mc;

endmodule
`default_nettype wire

// File: rtl/aes256_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_round_ctrl
//  Description : Iterative AES-256 encryption sequencer. Holds the single
//                state register of the encrypt path and steps one shared
//                round datapath through round 0 and NR further rounds,
//                fetching each round key with a request/valid handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_round_ctrl #(
    parameter int NR  = aes256_pkg::AES256_NR,
    parameter int RKW = aes256_pkg::RKW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    aes256_round_ctrl_if.slave bus
);

    localparam logic [1:0]     c_st_idle    = aes256_pkg::IDLE;
    localparam logic [1:0]     c_st_key     = aes256_pkg::KEY;
    localparam logic [1:0]     c_st_done    = aes256_pkg::DONE;
    localparam logic [RKW-1:0] c_last_round = RKW'(NR);
    localparam logic [RKW-1:0] c_round_inc  = RKW'(1);

    logic [1:0]     r_fsm;
    logic [127:0]   r_state;
    logic [RKW-1:0] r_round;

    logic           w_in_key;
    logic           w_first;
    logic           w_last;
    logic [127:0]   w_rf_out;
    logic [127:0]   w_ark_in;
    logic [127:0]   w_ark_out;

    assign w_in_key = (r_fsm == c_st_key);
    assign w_first  = (r_round == '0);
    assign w_last   = (r_round == c_last_round);

    // Shared round body; its output is discarded in round 0.
    aes256_round_func u_round_func (
        .state_i (r_state),
        .last_i  (w_last),
        .state_o (w_rf_out)
    );

    // Round 0 is a bare AddRoundKey, so the round function is bypassed there.
    assign w_ark_in = w_first ? r_state : w_rf_out;

    aes256_addroundkey u_addroundkey (
        .state_i (w_ark_in),
        .key_i   (bus.round_key_i),
        .state_o (w_ark_out)
    );

    // Sequencer: load plaintext, one round per key handshake, hold result until taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fsm   <= c_st_idle;
            r_state <= '0;
            r_round <= '0;
        end else begin
            case (r_fsm)
                c_st_idle: begin
                    if (bus.start_i) begin
                        r_state <= bus.data_i;
                        r_round <= '0;
                        r_fsm   <= c_st_key;
                    end
                end
                c_st_key: begin
                    if (bus.rk_valid_i) begin
                        r_state <= w_ark_out;
                        // The counter stops at NR; it never wraps.
                        if (w_last) begin
                            r_fsm <= c_st_done;
                        end else begin
                            r_round <= r_round + c_round_inc;
                        end
                    end
                end
                c_st_done: begin
                    if (bus.ready_i) begin
                        r_fsm <= c_st_idle;
                    end
                end
                default: begin
                    r_fsm <= c_st_idle;
                end
            endcase
        end
    end

    // All handshake outputs decode registered state only.
    assign bus.ready_o  = (r_fsm == c_st_idle);
    assign bus.rk_req_o = w_in_key;
    assign bus.rk_idx_o = w_in_key ? r_round : '0;
    assign bus.valid_o  = (r_fsm == c_st_done);
    assign bus.data_o   = r_state;

endmodule
`default_nettype wire
